// File: rtl/line_clear_engine_pkg.sv
// Shared grid geometry, types and arithmetic helpers for the line-clear engine.
package line_clear_engine_pkg;

    localparam int unsigned GRID_ROWS = 22;
    localparam int unsigned PLAY_ROWS = 20;
    localparam int unsigned GRID_COLS = 10;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned TOTAL_W   = 10;

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;

    typedef enum logic [1:0] {LC_IDLE, LC_SCAN, LC_DONE} lc_state_t;

    // Saturating accumulate of cleared lines; never wraps past all-ones.
    function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                   input logic [ROW_W-1:0]   b);
        logic [TOTAL_W:0] s;
        s = {1'b0, a} + {{(TOTAL_W-ROW_W+1){1'b0}}, b};
        return s[TOTAL_W] ? '1 : s[TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/line_clear_engine_if.sv
// Request/result bundle between the game FSM (master) and the line-clear engine (slave).
interface line_clear_engine_if;
    import line_clear_engine_pkg::*;

    logic                 start_i;
    grid_t                grid_i;
    logic                 busy_o;
    logic                 done_o;
    grid_t                grid_o;
    logic [ROW_W-1:0]     lines_o;
    logic [TOTAL_W-1:0]   total_lines_o;

    modport master (
        output start_i, grid_i,
        input  busy_o, done_o, grid_o, lines_o, total_lines_o
    );

    modport slave (
        input  start_i, grid_i,
        output busy_o, done_o, grid_o, lines_o, total_lines_o
    );

endinterface

// File: rtl/line_clear_engine_row_shift.sv
// Combinational row delete: removes row_i and drops every row above it by one.
module lc_row_shift
    import line_clear_engine_pkg::*;
(
    input  grid_t            grid_i,
    input  logic [ROW_W-1:0] row_i,
    output grid_t            grid_o
);

    always_comb begin
        grid_o    = grid_i;
        grid_o[0] = '0;
        for (int unsigned k = 1; k < GRID_ROWS; k++) begin
            if (k <= 32'(row_i)) begin
                grid_o[k] = grid_i[k-1];
            end
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Bottom-up scan that deletes full rows one per cycle and publishes the compacted grid.
module line_clear_engine
    import line_clear_engine_pkg::*;
(
    input logic               clk,
    input logic               reset,
    line_clear_engine_if.slave bus
);

    lc_state_t        state, state_next;
    grid_t            work, work_shifted, grid_masked;
    logic [ROW_W-1:0] r, n;
    logic             row_full;

    assign row_full    = &work[r];
    assign bus.busy_o  = (state != LC_IDLE);
    assign bus.done_o  = (state == LC_DONE);

    lc_row_shift u_row_shift (
        .grid_i (work),
        .row_i  (r),
        .grid_o (work_shifted)
    );

    always_comb begin
        grid_masked = bus.grid_i;
        for (int unsigned k = PLAY_ROWS; k < GRID_ROWS; k++) begin
            grid_masked[k] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LC_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LC_IDLE: if (bus.start_i) state_next = LC_SCAN;
            LC_SCAN: if (!row_full && r == '0) state_next = LC_DONE;
            LC_DONE: state_next = LC_IDLE;
            default: state_next = LC_IDLE;
        endcase
    end

    // A full row keeps r in place so the row dropped into it is re-checked next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work              <= '0;
            r                 <= '0;
            n                 <= '0;
            bus.grid_o        <= '0;
            bus.lines_o       <= '0;
            bus.total_lines_o <= '0;
        end else begin
            case (state)
                LC_IDLE: begin
                    if (bus.start_i) begin
                        work <= grid_masked;
                        r    <= ROW_W'(PLAY_ROWS - 1);
                        n    <= '0;
                    end
                end
                LC_SCAN: begin
                    if (row_full) begin
                        work <= work_shifted;
                        n    <= n + 1'b1;
                    end else if (r == '0) begin
                        bus.grid_o        <= work;
                        bus.lines_o       <= n;
                        bus.total_lines_o <= sat_add(bus.total_lines_o, n);
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: vector table plus busy, reset and saturation sequences.
module tb_line_clear_engine;
    import line_clear_engine_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    line_clear_engine_if bus ();

    line_clear_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_total = 0;

    typedef struct {
        string name;
        grid_t g;
        grid_t eg;
        int    lines;
        int    lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat_total(input int a, input int b);
        return (a + b > 1023) ? 1023 : a + b;
    endfunction

    task automatic run_pass(input string tag, input grid_t g, input grid_t eg,
                            input int el, input int lat_exp);
        int lat;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.grid_i  = g;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.grid_i  = '0;
        check({tag, "_busy"}, 256'(bus.busy_o), 256'(1));
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                lat = c;
                break;
            end
        end
        exp_total = sat_total(exp_total, el);
        check({tag, "_latency"}, 256'(lat), 256'(lat_exp));
        check({tag, "_grid"}, 256'(bus.grid_o), 256'(eg));
        check({tag, "_lines"}, 256'(bus.lines_o), 256'(el));
        check({tag, "_total"}, 256'(bus.total_lines_o), 256'(exp_total));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 256'({bus.done_o, bus.busy_o}), 256'(0));
    endtask

    initial begin
        grid_t g, eg, full;
        int lat, dones;

        full = '0;
        for (int k = 0; k < 20; k++) full[k] = 10'h3FF;

        vecs[0].name = "zero";
        vecs[0].g = '0; vecs[0].eg = '0; vecs[0].lines = 0; vecs[0].lat = 20;

        g = '0; g[19] = 10'h3FF; g[18] = 10'b0000110000;
        eg = '0; eg[19] = 10'b0000110000;
        vecs[1].name = "single";
        vecs[1].g = g; vecs[1].eg = eg; vecs[1].lines = 1; vecs[1].lat = 21;

        g = '0; for (int k = 16; k < 20; k++) g[k] = 10'h3FF; g[15] = 10'b1000000000;
        eg = '0; eg[19] = 10'b1000000000;
        vecs[2].name = "tetris";
        vecs[2].g = g; vecs[2].eg = eg; vecs[2].lines = 4; vecs[2].lat = 24;

        g = '0; g[19] = 10'h3FF; g[17] = 10'h3FF; g[18] = 10'b1000000001; g[16] = 10'b0000010000;
        eg = '0; eg[19] = 10'b1000000001; eg[18] = 10'b0000010000;
        vecs[3].name = "split";
        vecs[3].g = g; vecs[3].eg = eg; vecs[3].lines = 2; vecs[3].lat = 22;

        g = full; g[20] = 10'h3FF; g[21] = 10'h3FF;
        vecs[4].name = "full";
        vecs[4].g = g; vecs[4].eg = '0; vecs[4].lines = 20; vecs[4].lat = 40;

        bus.start_i = 1'b0;
        bus.grid_i  = '0;
        reset = 1'b1;
        #1;
        check("reset_state", 256'({bus.busy_o, bus.done_o, bus.lines_o, bus.total_lines_o}), 256'(0));
        check("reset_grid", 256'(bus.grid_o), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            run_pass(vecs[i].name, vecs[i].g, vecs[i].eg, vecs[i].lines, vecs[i].lat);

        // start_i at edge 5 and during DONE must both be dropped
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.grid_i  = vecs[1].g;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        dones = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (c == 4) begin
                bus.start_i = 1'b1;
                bus.grid_i  = full;
            end
            if (bus.done_o) begin
                lat = c;
                break;
            end
        end
        exp_total = sat_total(exp_total, 1);
        check("busy_latency", 256'(lat), 256'(21));
        check("busy_grid", 256'(bus.grid_o), 256'(vecs[1].eg));
        check("busy_lines", 256'(bus.lines_o), 256'(1));
        bus.start_i = 1'b1;
        bus.grid_i  = full;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check("done_start_ignored", 256'(bus.busy_o), 256'(0));
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        check("no_extra_done", 256'(dones), 256'(0));
        check("busy_total", 256'(bus.total_lines_o), 256'(exp_total));

        // reset mid-scan aborts and clears published results
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.grid_i  = full;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_reset_state", 256'({bus.busy_o, bus.done_o, bus.lines_o, bus.total_lines_o}), 256'(0));
        check("midrun_reset_grid", 256'(bus.grid_o), 256'(0));
        exp_total = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_pass("post_reset", '0, '0, 0, 20);

        for (int i = 0; i < 51; i++) run_pass("preset", full, '0, 20, 40);
        check("preset_total", 256'(bus.total_lines_o), 256'(1020));
        run_pass("sat_tetris", vecs[2].g, vecs[2].eg, 4, 24);
        check("sat_total", 256'(bus.total_lines_o), 256'(1023));
        run_pass("sat_hold", vecs[1].g, vecs[1].eg, 1, 21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
